// File: rtl/can_mc_pkg.sv
// Shared definitions for the CAN controller microcontroller interface:
// bus widths, register map landmarks, read-channel state encoding.
package can_mc_pkg;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;

   // Register map landmarks shared with the write channel
   localparam logic [ADDR_W-1:0] ADDR_INT      = 6'h04;
   localparam logic [ADDR_W-1:0] ADDR_LO_END   = 6'h11;
   localparam logic [ADDR_W-1:0] ADDR_HI_START = 6'h18;
   localparam logic [ADDR_W-1:0] ADDR_HI_END   = 6'h20;

   typedef enum logic [1:0] {
      IDLE,
      SELECT,
      RESP
   } rd_state_t;

   // 0x00-0x11 and 0x18-0x20 are readable; the 0x12-0x17 hole and 0x21+ are not
   function automatic logic is_readable(input logic [ADDR_W-1:0] addr);
      return (addr <= ADDR_LO_END) ||
             ((addr >= ADDR_HI_START) && (addr <= ADDR_HI_END));
   endfunction

endpackage

// File: rtl/can_rd_addr_decoder.sv
// Combinational read-address decoder: one-hot register select plus a
// mapped flag. Unmapped addresses produce an all-zero select.
module can_rd_addr_decoder
   import can_mc_pkg::*;
#(
   parameter int ADDR_W  = can_mc_pkg::ADDR_W,
   parameter int NUM_SEL = 33
) (
   input  logic [ADDR_W-1:0]  addr,
   output logic [NUM_SEL-1:0] sel,
   output logic               mapped
);

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      sel    = '0;
      mapped = is_readable(addr);
      for (int i = 0; i < NUM_SEL; i++) begin
         sel[i] = mapped && (addr == ADDR_W'(i));
      end
   end

endmodule

// File: rtl/can_read_channel.sv
// Read channel of the CAN microcontroller interface: decodes a host read,
// captures register-file data and returns it with a valid/ack handshake.
module can_read_channel
   import can_mc_pkg::*;
#(
   parameter int                ADDR_W      = can_mc_pkg::ADDR_W,
   parameter int                DATA_W      = can_mc_pkg::DATA_W,
   parameter int                NUM_SEL     = 33,
   parameter logic [ADDR_W-1:0] CLR_ADDR    = can_mc_pkg::ADDR_INT,
   parameter int                ACK_TIMEOUT = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rd_en,
   input  logic [ADDR_W-1:0]  i_addr,
   input  logic [DATA_W-1:0]  i_reg_r_bus,
   input  logic               i_rd_ack,
   output logic [NUM_SEL-1:0] rd_dec_addr,
   output logic [DATA_W-1:0]  o_bus_data,
   output logic               o_rd_valid,
   output logic               o_rd_err,
   output logic               o_rd_clr,
   output logic               o_busy
);

   localparam int CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam int TO_LAST_I = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

   rd_state_t          state;
   rd_state_t          next_state;
   logic [ADDR_W-1:0]  addr_q;
   logic [CNT_W-1:0]   cnt;
   logic [ADDR_W-1:0]  dec_in;
   logic [NUM_SEL-1:0] dec_sel;
   logic               dec_mapped;
   logic               accept;
   logic               timeout_hit;
   logic               resp_exit;

   // One decoder serves both the incoming address (mapped check) and the latched one (select)
   assign dec_in = (state == IDLE) ? i_addr : addr_q;

   can_rd_addr_decoder #(
      .ADDR_W  (ADDR_W),
      .NUM_SEL (NUM_SEL)
   ) u_dec (
      .addr   (dec_in),
      .sel    (dec_sel),
      .mapped (dec_mapped)
   );

   assign rd_dec_addr = (state == SELECT) ? dec_sel : '0;
   assign o_busy      = (state != IDLE);
   assign timeout_hit = (ACK_TIMEOUT > 0) && (cnt == TO_LAST);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      resp_exit  = 1'b0;
      case (state)
         IDLE: begin
            if (i_rd_en) begin
               accept     = 1'b1;
               next_state = dec_mapped ? SELECT : RESP;
            end
         end
         SELECT: next_state = RESP;
         RESP: begin
            if (i_rd_ack || timeout_hit) begin
               resp_exit  = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Response registers are all loaded on RESP entry so they stay stable for the whole state
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         addr_q     <= '0;
         cnt        <= '0;
         o_bus_data <= '0;
         o_rd_valid <= 1'b0;
         o_rd_err   <= 1'b0;
         o_rd_clr   <= 1'b0;
      end else begin
         o_rd_clr <= 1'b0;
         if (accept) addr_q <= i_addr;
         case (state)
            IDLE: begin
               if (accept && !dec_mapped) begin
                  o_bus_data <= '0;
                  o_rd_valid <= 1'b1;
                  o_rd_err   <= 1'b1;
                  cnt        <= '0;
               end
            end
            SELECT: begin
               o_bus_data <= i_reg_r_bus;
               o_rd_valid <= 1'b1;
               o_rd_err   <= 1'b0;
               o_rd_clr   <= (addr_q == CLR_ADDR);
               cnt        <= '0;
            end
            RESP: begin
               if (resp_exit) begin
                  o_bus_data <= '0;
                  o_rd_valid <= 1'b0;
                  o_rd_err   <= 1'b0;
                  cnt        <= '0;
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/can_read_channel.md
Name: can_read_channel

Overview:
- Read channel of the CAN controller Microcontroller Interface; counterpart of the write channel inside the same interface.
- Accepts a host read request (address strobe), decodes it to a one-hot register select, and captures the selected register's data from the register file's read mux.
- Presents the captured data to the host with a valid/acknowledge handshake.
- Generates a read-to-clear pulse for the interrupt register and flags reads of unmapped addresses.

Parameters:
- ADDR_W, 6, host address width
- DATA_W, 32, data bus width
- NUM_SEL, 33, width of register select vector; bit n selects address n (0x00..0x20)
- CLR_ADDR, 6'h04, address whose read generates the read-to-clear pulse (interrupt register)
- ACK_TIMEOUT, 16, cycles RESP waits for i_rd_ack before abandoning; 0 = wait forever

Ports:
- i_clk, input, 1, interface clock
- i_reset, input, 1, asynchronous active-high reset
- i_rd_en, input, 1, read request strobe; sampled only when o_busy=0
- i_addr, input, ADDR_W, read address; sampled together with i_rd_en
- i_reg_r_bus, input, DATA_W, data returned by register file for the currently asserted select
- i_rd_ack, input, 1, host has consumed o_bus_data
- rd_dec_addr, output, NUM_SEL, one-hot register select to register file
- o_bus_data, output, DATA_W, read data to host
- o_rd_valid, output, 1, o_bus_data valid
- o_rd_err, output, 1, qualifies o_rd_valid: unmapped address read
- o_rd_clr, output, 1, one-cycle read-to-clear pulse for CLR_ADDR
- o_busy, output, 1, channel is processing a request

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; latched address 0; timeout counter 0. No o_rd_clr pulse is generated for a transaction aborted by reset.
- Readable map: 0x00-0x03, 0x04 (interrupt, read-to-clear), 0x05, 0x06-0x07 (status/error counters, read-only), 0x08-0x11, 0x18-0x20. Any other address is unmapped.
- IDLE:
  - o_busy=0.
  - i_rd_en=1 latches i_addr; next state is SELECT for a mapped address, RESP with error for an unmapped one.
- SELECT (exactly 1 cycle):
  - o_busy=1; rd_dec_addr[addr]=1, all other bits 0.
  - The register file drives i_reg_r_bus combinationally; it is registered into o_bus_data at the end of this cycle.
  - Next state: RESP.
- RESP:
  - o_busy=1, o_rd_valid=1; o_bus_data and o_rd_err are stable for the whole state.
  - rd_dec_addr=0.
  - On the first RESP cycle only: o_rd_clr=1 if the latched address equals CLR_ADDR and o_rd_err=0.
  - Exit on i_rd_ack=1: next cycle IDLE; o_rd_valid, o_rd_err and o_bus_data return to 0.
  - Exit on timeout: if ACK_TIMEOUT>0 and the counter reaches ACK_TIMEOUT with no ack, go to IDLE and clear outputs identically to an ack.
- Unmapped read: no SELECT cycle; o_bus_data=0, o_rd_err=1, o_rd_valid=1, no o_rd_clr.
- Latency: a mapped read shows o_rd_valid 2 cycles after the i_rd_en sample edge; an unmapped read shows it after 1 cycle.
- i_rd_en while o_busy=1 is ignored (no queueing).
- i_rd_ack outside RESP is ignored.
- Ack in the same cycle that RESP is entered is not possible: o_rd_valid is registered, so the earliest ack is on the first RESP cycle, and it is honoured.
- The timeout counter saturates, resets on RESP entry, and is DATA-independent.

Decomposition:
- Shared package can_mc_pkg:
  - ADDR_W and DATA_W.
  - Register address constants (shared with the write channel).
  - State enum {IDLE, SELECT, RESP}.
  - Function is_readable(addr).
- One natural sub-module: can_rd_addr_decoder (combinational: address -> one-hot select plus mapped flag). The FSM, capture register and timeout counter stay in the top module.

Test Plan:
1. Mapped read:
   - Stimulus: reset, then i_rd_en=1 with i_addr=0x0A; register file returns 0xDEADBEEF while rd_dec_addr[10]=1.
   - Required: rd_dec_addr=1<<10 for exactly 1 cycle; o_rd_valid=1 two cycles later with o_bus_data=0xDEADBEEF and o_rd_err=0; outputs hold until i_rd_ack; IDLE on the next cycle.
2. Unmapped read:
   - Stimulus: read 0x13.
   - Required: rd_dec_addr stays 0; o_rd_valid=1 and o_rd_err=1 with o_bus_data=0 after 1 cycle; no o_rd_clr.
3. Read-to-clear:
   - Stimulus: read 0x04 returning 0x00000005.
   - Required: o_rd_clr=1 for exactly one cycle (first RESP cycle); data=0x5. Reading 0x06 produces no o_rd_clr.
4. Busy and timeout:
   - Stimulus: i_rd_en with 0x00 issued during RESP of a read of 0x20; no ack is given.
   - Required: the second request is ignored; after 16 RESP cycles the channel returns to IDLE with o_rd_valid=0.
5. Reset mid-op:
   - Stimulus: assert i_reset asynchronously during SELECT of a read of 0x04.
   - Required: all outputs 0 immediately; no o_rd_clr; the next read of 0x01 completes normally.
6. Back-to-back:
   - Stimulus: ack on the first RESP cycle, and i_rd_en for 0x1F on the cycle after.
   - Required: the second read completes with rd_dec_addr[31]=1 and correct data, with no lost or duplicated transaction.
